// File: rtl/trace_pkg.sv
// Shared definitions for the execution trace monitor.
// Holds the monitor state encoding, the bit positions of the record kind
// flags, and helpers that give the offset/width of each record field:
//   record = {kind, pc, write_reg, write_data, mem_addr, mem_data}
//   (mem_data occupies the least significant bits)
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  localparam int unsigned KIND_REG_WRITE = 0;
  localparam int unsigned KIND_MEM_READ  = 1;
  localparam int unsigned KIND_MEM_WRITE = 2;
  localparam int unsigned KIND_HALT      = 3;
  localparam int unsigned KIND_W         = 4;

  function automatic int unsigned memDataLsb(input int unsigned dataW);
    memDataLsb = 0;
  endfunction

  function automatic int unsigned memAddrLsb(input int unsigned dataW);
    memAddrLsb = dataW;
  endfunction

  function automatic int unsigned writeDataLsb(input int unsigned dataW);
    writeDataLsb = 2 * dataW;
  endfunction

  function automatic int unsigned writeRegLsb(input int unsigned dataW);
    writeRegLsb = 3 * dataW;
  endfunction

  function automatic int unsigned pcLsb(input int unsigned dataW, input int unsigned regW);
    pcLsb = 3 * dataW + regW;
  endfunction

  function automatic int unsigned kindLsb(input int unsigned dataW, input int unsigned regW);
    kindLsb = 4 * dataW + regW;
  endfunction

  function automatic int unsigned recWidth(input int unsigned dataW, input int unsigned regW);
    recWidth = KIND_W + 4 * dataW + regW;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO.
// Ports:
//   clk, rst   clock and synchronous active-high reset (empties the FIFO)
//   push, din  write request and data; ignored when full unless a pop
//              happens in the same cycle
//   pop        read request; ignored when empty
//   dout       head entry, valid whenever empty=0
//   full/empty occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign doPop  = pop && !empty;
  // A full FIFO can still accept a write when the head leaves this cycle.
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trace_monitor.sv
// Execution trace monitor.
// Watches the retire/writeback/memory signals of a core while running and
// packs every event cycle into one record pushed to a FWFT record FIFO.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en                       start capture (IDLE -> RUN)
//   pc, reg_write, write_reg, write_data,
//   mem_read, mem_write, mem_addr, mem_wdata, mem_rdata, halt
//                            observed core activity
//   rec_valid/rec_ready/rec_data  record stream out (valid/ready)
//   cycle_count              cycles spent in RUN
//   inst_count               retired instructions (halt|reg_write|mem_write)
//   drop_count, overflow     records lost to a full FIFO, sticky loss flag
//   done, timeout            terminal state indicators
module trace_monitor
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_W      = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_CYCLES = 100000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [DATA_W-1:0]                   pc,
  input  logic                                reg_write,
  input  logic [REG_W-1:0]                    write_reg,
  input  logic [DATA_W-1:0]                   write_data,
  input  logic                                mem_read,
  input  logic                                mem_write,
  input  logic [DATA_W-1:0]                   mem_addr,
  input  logic [DATA_W-1:0]                   mem_wdata,
  input  logic [DATA_W-1:0]                   mem_rdata,
  input  logic                                halt,
  output logic                                rec_valid,
  input  logic                                rec_ready,
  output logic [4+3*DATA_W+DATA_W+REG_W-1:0]  rec_data,
  output logic [CNT_W-1:0]                    cycle_count,
  output logic [CNT_W-1:0]                    inst_count,
  output logic [CNT_W-1:0]                    drop_count,
  output logic                                overflow,
  output logic                                done,
  output logic                                timeout
);

  localparam int unsigned REC_W       = recWidth(DATA_W, REG_W);
  localparam int unsigned MDATA_LSB   = memDataLsb(DATA_W);
  localparam int unsigned MADDR_LSB   = memAddrLsb(DATA_W);
  localparam int unsigned WDATA_LSB   = writeDataLsb(DATA_W);
  localparam int unsigned WREG_LSB    = writeRegLsb(DATA_W);
  localparam int unsigned PC_LSB      = pcLsb(DATA_W, REG_W);
  localparam int unsigned KIND_LSB    = kindLsb(DATA_W, REG_W);
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  state_t            state;
  state_t            stateNext;
  logic [KIND_W-1:0] kind;
  logic [REC_W-1:0]  recIn;
  logic              inRun;
  logic              isEvent;
  logic              retires;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              doPop;
  logic              doPush;
  logic              doDrop;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    satInc = (v == '1) ? v : v + 1'b1;
  endfunction

  assign inRun   = (state == RUN);
  assign done    = (state == HALTED);
  assign timeout = (state == TIMEOUT);

  always_comb begin
    kind                 = '0;
    kind[KIND_REG_WRITE] = reg_write;
    kind[KIND_MEM_READ]  = mem_read;
    kind[KIND_MEM_WRITE] = mem_write;
    kind[KIND_HALT]      = halt;
  end

  assign isEvent = inRun && (kind != '0);
  assign retires = inRun && (halt || reg_write || mem_write);

  // Record packing: fields belonging to event types absent from kind are zero.
  always_comb begin
    recIn                          = '0;
    recIn[KIND_LSB +: KIND_W]      = kind;
    recIn[PC_LSB +: DATA_W]        = pc;
    if (reg_write) begin
      recIn[WREG_LSB +: REG_W]     = write_reg;
      recIn[WDATA_LSB +: DATA_W]   = write_data;
    end
    if (mem_read || mem_write) begin
      recIn[MADDR_LSB +: DATA_W]   = mem_addr;
    end
    if (mem_write) begin
      recIn[MDATA_LSB +: DATA_W]   = mem_wdata;
    end else if (mem_read) begin
      recIn[MDATA_LSB +: DATA_W]   = mem_rdata;
    end
  end

  assign rec_valid = !fifoEmpty;
  assign doPop     = rec_valid && rec_ready;
  assign doPush    = isEvent && (!fifoFull || doPop);
  assign doDrop    = isEvent && fifoFull && !doPop;

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (doPush),
    .pop   (doPop),
    .din   (recIn),
    .dout  (rec_data),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (en) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        // A halt on the final allowed cycle wins over the timeout.
        if (halt) begin
          stateNext = HALTED;
        end else if (cycle_count == LAST_CYCLE) begin
          stateNext = TIMEOUT;
        end
      end
      default: stateNext = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      inst_count  <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (inRun) begin
        cycle_count <= satInc(cycle_count);
      end
      if (retires) begin
        inst_count <= satInc(inst_count);
      end
      if (doDrop) begin
        drop_count <= satInc(drop_count);
        overflow   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_monitor.sv
module tb_trace_monitor;

  localparam int unsigned DW    = 16;
  localparam int unsigned RW    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXC  = 10;
  localparam int unsigned CW    = 32;
  localparam int unsigned RECW  = 4 + 4 * DW + RW;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [DW-1:0]   pc;
  logic            reg_write;
  logic [RW-1:0]   write_reg;
  logic [DW-1:0]   write_data;
  logic            mem_read;
  logic            mem_write;
  logic [DW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            halt;
  logic            rec_valid;
  logic            rec_ready;
  logic [RECW-1:0] rec_data;
  logic [CW-1:0]   cycle_count;
  logic [CW-1:0]   inst_count;
  logic [CW-1:0]   drop_count;
  logic            overflow;
  logic            done;
  logic            timeout;

  always #5 clk = ~clk;

  trace_monitor #(
    .DATA_W     (DW),
    .REG_W      (RW),
    .DEPTH      (DEPTH),
    .MAX_CYCLES (MAXC),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pc          (pc),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .halt        (halt),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_data    (rec_data),
    .cycle_count (cycle_count),
    .inst_count  (inst_count),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .done        (done),
    .timeout     (timeout)
  );

  typedef enum {M_IDLE, M_RUN, M_HALTED, M_TIMEOUT} mstate_t;

  int unsigned     checks = 0;
  int unsigned     errors = 0;
  logic [RECW-1:0] sb[$];
  mstate_t         mState = M_IDLE;
  logic [CW-1:0]   mCyc   = '0;
  logic [CW-1:0]   mInst  = '0;
  logic [CW-1:0]   mDrop  = '0;
  logic            mOvf   = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RECW-1:0] expRec();
    logic [3:0] k;
    k = {halt, mem_write, mem_read, reg_write};
    expRec = {k, pc,
              reg_write ? write_reg : 4'h0,
              reg_write ? write_data : 16'h0,
              (mem_read || mem_write) ? mem_addr : 16'h0,
              mem_write ? mem_wdata : (mem_read ? mem_rdata : 16'h0)};
  endfunction

  task automatic clearIn();
    en = 1'b0; pc = '0; reg_write = 1'b0; write_reg = '0; write_data = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    mem_rdata = '0; halt = 1'b0;
  endtask

  // One clock cycle: check outputs against the model, take the edge, update
  // the model (scoreboard push on accepted event, pop on handshake).
  task automatic tick();
    logic            popNow;
    logic            evNow;
    logic            instNow;
    logic [RECW-1:0] newRec;
    #1;
    chk("rec_valid", rec_valid, sb.size() != 0);
    chk("cycle_count", cycle_count, mCyc);
    chk("inst_count", inst_count, mInst);
    chk("drop_count", drop_count, mDrop);
    chk("overflow", overflow, mOvf);
    chk("done", done, mState == M_HALTED);
    chk("timeout", timeout, mState == M_TIMEOUT);
    popNow = (sb.size() != 0) && rec_ready;
    if (popNow) chk("rec_data", rec_data, sb[0]);
    evNow   = (mState == M_RUN) && (reg_write || mem_read || mem_write || halt);
    instNow = (mState == M_RUN) && (reg_write || mem_write || halt);
    newRec  = expRec();
    @(posedge clk);
    if (rst) begin
      sb.delete();
      mState = M_IDLE; mCyc = '0; mInst = '0; mDrop = '0; mOvf = 1'b0;
    end else begin
      if (popNow) void'(sb.pop_front());
      if (evNow) begin
        if (sb.size() < DEPTH) sb.push_back(newRec);
        else begin mDrop++; mOvf = 1'b1; end
      end
      if (instNow) mInst++;
      case (mState)
        M_IDLE: if (en) mState = M_RUN;
        M_RUN: begin
          if (halt) mState = M_HALTED;
          else if (mCyc == MAXC - 1) mState = M_TIMEOUT;
          mCyc++;
        end
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    clearIn(); rec_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic startRun();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  initial begin
    clearIn(); rec_ready = 1'b0; rst = 1'b1;
    @(negedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", rec_valid, 1'b0);
    chk("reset_cycles", cycle_count, 0);
    chk("reset_done", done, 1'b0);

    // Basic capture, then a load event
    startRun();
    rec_ready = 1'b1;
    reg_write = 1'b1; write_reg = 4'd3; write_data = 16'h1234; pc = 16'h0004;
    tick();
    clearIn();
    chk("basic_kind", rec_data[71:68], 4'b0001);
    chk("basic_wreg", rec_data[51:48], 4'd3);
    chk("basic_wdata", rec_data[47:32], 16'h1234);
    chk("basic_pc", rec_data[67:52], 16'h0004);
    mem_read = 1'b1; mem_addr = 16'h0020; mem_rdata = 16'h7777; mem_wdata = 16'h1111;
    pc = 16'h0006;
    tick();
    clearIn();
    chk("basic_inst", inst_count, 1);
    chk("load_mdata", rec_data[15:0], 16'h7777);
    tick();
    tick();

    // Combined store + halt
    doReset();
    startRun();
    mem_write = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'hBEEF; mem_rdata = 16'h5555;
    halt = 1'b1; pc = 16'h0008;
    tick();
    clearIn();
    chk("halt_done", done, 1'b1);
    chk("halt_kind", rec_data[71:68], 4'b1100);
    chk("halt_mdata", rec_data[15:0], 16'hBEEF);
    chk("halt_maddr", rec_data[31:16], 16'h0010);
    chk("halt_wdata", rec_data[47:32], 16'h0000);
    reg_write = 1'b1; write_data = 16'h0009;
    tick();
    clearIn();
    chk("halt_ignore_inst", inst_count, 1);
    rec_ready = 1'b1;
    tick();
    tick();
    chk("halt_drained", rec_valid, 1'b0);

    // Overflow with DEPTH=4
    doReset();
    startRun();
    for (int i = 0; i < 6; i++) begin
      reg_write = 1'b1; write_reg = 4'(i); write_data = 16'h0100 + 16'(i); pc = 16'(i * 2);
      tick();
    end
    clearIn();
    chk("ovf_drop", drop_count, 2);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_inst", inst_count, 6);
    chk("ovf_head", rec_data[47:32], 16'h0100);
    rec_ready = 1'b1;
    repeat (5) tick();
    chk("ovf_empty", rec_valid, 1'b0);

    // Full FIFO with pop and event together
    doReset();
    startRun();
    for (int i = 0; i < 4; i++) begin
      reg_write = 1'b1; write_data = 16'h0200 + 16'(i);
      tick();
    end
    reg_write = 1'b1; write_data = 16'hAAAA; rec_ready = 1'b1;
    tick();
    clearIn();
    chk("fullpop_drop", drop_count, 0);
    chk("fullpop_ovf", overflow, 1'b0);
    repeat (3) tick();
    chk("fullpop_last", rec_data[47:32], 16'hAAAA);
    repeat (2) tick();

    // Timeout
    doReset();
    startRun();
    repeat (10) tick();
    chk("to_flag", timeout, 1'b1);
    chk("to_cycles", cycle_count, 10);
    tick();
    chk("to_cycles_hold", cycle_count, 10);

    // Reset mid-run with buffered records and a pending pop
    doReset();
    startRun();
    for (int i = 0; i < 3; i++) begin
      reg_write = 1'b1; write_data = 16'h0300 + 16'(i);
      tick();
    end
    clearIn();
    rec_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; rec_ready = 1'b0;
    chk("rr_valid", rec_valid, 1'b0);
    chk("rr_cycles", cycle_count, 0);
    chk("rr_inst", inst_count, 0);
    chk("rr_drop", drop_count, 0);
    chk("rr_done", done, 1'b0);
    reg_write = 1'b1; write_data = 16'h0DEF;
    tick();
    clearIn();
    chk("rr_idle_ignore", rec_valid, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
